// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - op encodings carried on req_op
//   - FSM state enum used by lsu_mem_ctrl
//   - op decode helpers: access size in bytes, signedness, legality
package lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_D  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam logic [2:0] OP_WU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT1 = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_BEAT2 = 3'd3,
    ST_WAIT2 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_e;

  // Access size in bytes; 0 marks the unused encoding.
  function automatic logic [3:0] op_size(input logic [2:0] op);
    case (op)
      OP_B, OP_BU: op_size = 4'd1;
      OP_H, OP_HU: op_size = 4'd2;
      OP_W, OP_WU: op_size = 4'd4;
      OP_D:        op_size = 4'd8;
      default:     op_size = 4'd0;
    endcase
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    case (op)
      OP_B, OP_H, OP_W, OP_D: op_signed = 1'b1;
      default:                op_signed = 1'b0;
    endcase
  endfunction

  // Doubleword ops only exist on a 64-bit datapath.
  function automatic logic op_legal(input logic [2:0] op, input logic is64);
    case (op)
      OP_D, OP_WU: op_legal = is64;
      3'b111:      op_legal = 1'b0;
      default:     op_legal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
//   Write path: i_wdata/i_woff/i_wsize -> lane-positioned data and byte mask
//               for beat 1 (o_wdata1/o_mask1) and the spill beat (o_wdata2/o_mask2).
//   Read path : i_buf0/i_buf1 (beat 1/2 read data), i_roff, i_rsize, i_rsigned
//               -> o_rdata, extracted and sign/zero extended.
module lsu_lane_align #(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OW   = $clog2(NB)
) (
  input  logic [XLEN-1:0] i_wdata,
  input  logic [OW-1:0]   i_woff,
  input  logic [3:0]      i_wsize,
  output logic [XLEN-1:0] o_wdata1,
  output logic [XLEN-1:0] o_wdata2,
  output logic [NB-1:0]   o_mask1,
  output logic [NB-1:0]   o_mask2,
  input  logic [XLEN-1:0] i_buf0,
  input  logic [XLEN-1:0] i_buf1,
  input  logic [OW-1:0]   i_roff,
  input  logic [3:0]      i_rsize,
  input  logic            i_rsigned,
  output logic [XLEN-1:0] o_rdata
);

  logic [2*NB-1:0]   w_lowmask;
  logic [2*NB-1:0]   w_mask_full;
  logic [2*XLEN-1:0] w_data_full;
  logic [XLEN-1:0]   w_raw;
  logic              w_sign;
  logic              w_fill;

  // Write path: shift over a double-width window; the upper half is what
  // spills into the next aligned word.
  always_comb begin
    w_lowmask = '0;
    for (int k = 0; k < NB; k++) begin
      w_lowmask[k] = (4'(k) < i_wsize);
    end
    w_mask_full = w_lowmask << i_woff;
    w_data_full = {{XLEN{1'b0}}, i_wdata} << {i_woff, 3'b000};
    o_mask1     = w_mask_full[NB-1:0];
    o_mask2     = w_mask_full[2*NB-1:NB];
    o_wdata1    = w_data_full[XLEN-1:0];
    o_wdata2    = w_data_full[2*XLEN-1:XLEN];
  end

  // Read path: merge both beats, keep the low size bytes, fill the rest.
  always_comb begin
    w_raw  = XLEN'({i_buf1, i_buf0} >> {i_roff, 3'b000});
    w_sign = 1'b0;
    for (int k = 0; k < NB; k++) begin
      w_sign = (4'(k + 1) == i_rsize) ? w_raw[8*k+7] : w_sign;
    end
    w_fill  = i_rsigned & w_sign;
    o_rdata = '0;
    for (int k = 0; k < NB; k++) begin
      o_rdata[8*k +: 8] = (4'(k) < i_rsize) ? w_raw[8*k +: 8] : {8{w_fill}};
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: sequential load/store unit between execute and data memory.
//   Request side : i_req_valid/o_req_ready, i_req_wen, i_req_op, i_req_addr, i_req_wdata
//   Response side: o_resp_valid/i_resp_ready, o_resp_rdata, o_resp_err
//   Memory side  : o_mem_req_valid/i_mem_req_ready, o_mem_req_wen/addr/wdata/wmask,
//                  i_mem_resp_valid, i_mem_resp_rdata
//   One transaction in flight; boundary-crossing accesses become two aligned beats.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_wen,
  input  logic [2:0]          i_req_op,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [XLEN-1:0]     i_req_wdata,
  output logic                o_resp_valid,
  input  logic                i_resp_ready,
  output logic [XLEN-1:0]     o_resp_rdata,
  output logic                o_resp_err,
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic                o_mem_req_wen,
  output logic [ADDR_W-1:0]   o_mem_req_addr,
  output logic [XLEN-1:0]     o_mem_req_wdata,
  output logic [XLEN/8-1:0]   o_mem_req_wmask,
  input  logic                i_mem_resp_valid,
  input  logic [XLEN-1:0]     i_mem_resp_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lsu_state_e        r_state;
  logic              r_wen, r_signed, r_cross;
  logic [3:0]        r_size;
  logic [OW-1:0]     r_off;
  logic [ADDR_W-1:0] r_aligned;
  logic [XLEN-1:0]   r_wdata2, r_buf0, r_buf1;
  logic [NB-1:0]     r_mask2;
  logic              r_req_ready, r_resp_valid, r_resp_err;
  logic [XLEN-1:0]   r_resp_rdata;
  logic              r_mem_req_valid, r_mem_req_wen;
  logic [ADDR_W-1:0] r_mem_req_addr;
  logic [XLEN-1:0]   r_mem_req_wdata;
  logic [NB-1:0]     r_mem_req_wmask;

  logic [3:0]        w_size;
  logic [OW-1:0]     w_off;
  logic [4:0]        w_end;
  logic              w_cross, w_reject;
  logic [ADDR_W-1:0] w_aligned;
  logic [XLEN-1:0]   w_wdata1, w_wdata2, w_rbuf0, w_rbuf1, w_rdata, w_load_data;
  logic [NB-1:0]     w_mask1, w_mask2;

  assign w_size    = op_size(i_req_op);
  assign w_off     = i_req_addr[OW-1:0];
  assign w_end     = 5'(w_off) + 5'(w_size);
  assign w_cross   = (w_end > 5'(NB));
  assign w_reject  = !op_legal(i_req_op, XLEN == 64) || (w_cross && (ALLOW_MISALIGN == 0));
  assign w_aligned = {i_req_addr[ADDR_W-1:OW], {OW{1'b0}}};

  // The completing beat's data bypasses its buffer so resp_valid can rise
  // on the edge right after mem_resp_valid.
  always_comb begin
    w_rbuf0 = r_buf0;
    w_rbuf1 = r_buf1;
    case (r_state)
      ST_WAIT1: w_rbuf0 = i_mem_resp_rdata;
      ST_WAIT2: w_rbuf1 = i_mem_resp_rdata;
      default:  w_rbuf0 = r_buf0;
    endcase
  end

  // Write path sees the live request (beat 1 is launched on the accept edge);
  // read path sees registered access parameters.
  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .i_wdata  (i_req_wdata),
    .i_woff   (w_off),
    .i_wsize  (w_size),
    .o_wdata1 (w_wdata1),
    .o_wdata2 (w_wdata2),
    .o_mask1  (w_mask1),
    .o_mask2  (w_mask2),
    .i_buf0   (w_rbuf0),
    .i_buf1   (w_rbuf1),
    .i_roff   (r_off),
    .i_rsize  (r_size),
    .i_rsigned(r_signed),
    .o_rdata  (w_rdata)
  );

  assign w_load_data = r_wen ? '0 : w_rdata;

  // Transaction FSM with registered handshake and memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_wen           <= 1'b0;
      r_signed        <= 1'b0;
      r_cross         <= 1'b0;
      r_size          <= 4'd0;
      r_off           <= '0;
      r_aligned       <= '0;
      r_wdata2        <= '0;
      r_mask2         <= '0;
      r_buf0          <= '0;
      r_buf1          <= '0;
      r_req_ready     <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_resp_err      <= 1'b0;
      r_resp_rdata    <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_wen   <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_wdata <= '0;
      r_mem_req_wmask <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_wen       <= i_req_wen;
            r_signed    <= op_signed(i_req_op);
            r_size      <= w_size;
            r_off       <= w_off;
            r_cross     <= w_cross;
            r_aligned   <= w_aligned;
            r_wdata2    <= w_wdata2;
            r_mask2     <= w_mask2;
            if (w_reject) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state         <= ST_BEAT1;
              r_mem_req_valid <= 1'b1;
              r_mem_req_wen   <= i_req_wen;
              r_mem_req_addr  <= w_aligned;
              r_mem_req_wdata <= w_wdata1;
              r_mem_req_wmask <= w_mask1;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_BEAT1: begin
          if (i_mem_req_ready) begin
            r_state         <= ST_WAIT1;
            r_mem_req_valid <= 1'b0;
          end
        end
        ST_WAIT1: begin
          if (i_mem_resp_valid) begin
            r_buf0 <= i_mem_resp_rdata;
            if (r_cross) begin
              r_state         <= ST_BEAT2;
              r_mem_req_valid <= 1'b1;
              r_mem_req_addr  <= r_aligned + ADDR_W'(NB);
              r_mem_req_wdata <= r_wdata2;
              r_mem_req_wmask <= r_mask2;
            end else begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= w_load_data;
            end
          end
        end
        ST_BEAT2: begin
          if (i_mem_req_ready) begin
            r_state         <= ST_WAIT2;
            r_mem_req_valid <= 1'b0;
          end
        end
        ST_WAIT2: begin
          if (i_mem_resp_valid) begin
            r_buf1       <= i_mem_resp_rdata;
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load_data;
          end
        end
        ST_RESP: begin
          if (i_resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready     = r_req_ready;
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_err      = r_resp_err;
  assign o_resp_rdata    = r_resp_rdata;
  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_req_wen   = r_mem_req_wen;
  assign o_mem_req_addr  = r_mem_req_addr;
  assign o_mem_req_wdata = r_mem_req_wdata;
  assign o_mem_req_wmask = r_mem_req_wmask;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT: XLEN=32, misaligned splitting enabled
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  // Second DUT: misaligned accesses rejected
  logic        n_req_valid, n_req_ready, n_req_wen;
  logic [2:0]  n_req_op;
  logic [31:0] n_req_addr, n_req_wdata;
  logic        n_resp_valid, n_resp_ready, n_resp_err;
  logic [31:0] n_resp_rdata;
  logic        n_mem_req_valid, n_mem_req_ready, n_mem_req_wen;
  logic [31:0] n_mem_req_addr, n_mem_req_wdata;
  logic [3:0]  n_mem_req_wmask;
  logic        n_mem_resp_valid;
  logic [31:0] n_mem_resp_rdata;

  lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
    .i_req_op(req_op), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready),
    .o_mem_req_wen(mem_req_wen), .o_mem_req_addr(mem_req_addr),
    .o_mem_req_wdata(mem_req_wdata), .o_mem_req_wmask(mem_req_wmask),
    .i_mem_resp_valid(mem_resp_valid), .i_mem_resp_rdata(mem_resp_rdata)
  );

  lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGN(0)) dut_na (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(n_req_valid), .o_req_ready(n_req_ready), .i_req_wen(n_req_wen),
    .i_req_op(n_req_op), .i_req_addr(n_req_addr), .i_req_wdata(n_req_wdata),
    .o_resp_valid(n_resp_valid), .i_resp_ready(n_resp_ready),
    .o_resp_rdata(n_resp_rdata), .o_resp_err(n_resp_err),
    .o_mem_req_valid(n_mem_req_valid), .i_mem_req_ready(n_mem_req_ready),
    .o_mem_req_wen(n_mem_req_wen), .o_mem_req_addr(n_mem_req_addr),
    .o_mem_req_wdata(n_mem_req_wdata), .o_mem_req_wmask(n_mem_req_wmask),
    .i_mem_resp_valid(n_mem_resp_valid), .i_mem_resp_rdata(n_mem_resp_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;   // what the memory model returns for this beat
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_beat(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                             input logic [3:0] mask, input logic [31:0] rdata);
    beat_t b;
    b.addr = addr; b.wen = wen; b.wdata = wdata; b.mask = mask; b.rdata = rdata;
    beat_q.push_back(b);
  endtask

  task automatic expect_resp(input logic [31:0] rdata, input logic err);
    resp_t r;
    r.rdata = rdata; r.err = err;
    resp_q.push_back(r);
  endtask

  task automatic send_req(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Checks the pending beat (no wait allowed), optionally stalls the
  // request handshake, then completes it with one response cycle.
  task automatic serve_beat(input int stall);
    beat_t b;
    b = beat_q.pop_front();
    chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("mem_req_addr",  mem_req_addr, b.addr);
    chk("mem_req_wen",   32'(mem_req_wen), 32'(b.wen));
    chk("mem_req_wdata", mem_req_wdata, b.wdata);
    chk("mem_req_wmask", 32'(mem_req_wmask), 32'(b.mask));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(mem_req_valid), 32'd1);
      chk("stall_addr",  mem_req_addr, b.addr);
      chk("stall_wdata", mem_req_wdata, b.wdata);
      chk("stall_wmask", 32'(mem_req_wmask), 32'(b.mask));
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk("mem_req_drop", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1; mem_resp_rdata = b.rdata;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
  endtask

  task automatic take_resp(input int stall);
    resp_t r;
    r = resp_q.pop_front();
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_rdata", resp_rdata, r.rdata);
    chk("resp_err",   32'(resp_err), 32'(r.err));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, r.rdata);
      chk("hold_err",   32'(resp_err), 32'(r.err));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_err"},   32'(resp_err), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_mem_valid"},  32'(mem_req_valid), 32'd0);
    chk({tag, "_mem_wen"},    32'(mem_req_wen), 32'd0);
    chk({tag, "_mem_addr"},   mem_req_addr, 32'd0);
    chk({tag, "_mem_wdata"},  mem_req_wdata, 32'd0);
    chk({tag, "_mem_wmask"},  32'(mem_req_wmask), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
    n_req_valid = 1'b0; n_req_wen = 1'b0; n_req_op = 3'd0; n_req_addr = 32'h0; n_req_wdata = 32'h0;
    n_resp_ready = 1'b0; n_mem_req_ready = 1'b0; n_mem_resp_valid = 1'b0; n_mem_resp_rdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Store word, single beat
    expect_beat(32'h100, 1'b1, 32'hDEADBEEF, 4'b1111, 32'h0);
    expect_resp(32'h0, 1'b0);
    send_req(1'b1, OP_W, 32'h100, 32'hDEADBEEF);
    serve_beat(0);
    take_resp(0);

    // Store byte into top lane; upper request bytes are ignored
    expect_beat(32'h100, 1'b1, 32'hAB000000, 4'b1000, 32'h0);
    expect_resp(32'h0, 1'b0);
    send_req(1'b1, OP_B, 32'h103, 32'h123456AB);
    serve_beat(0);
    take_resp(0);

    // Load byte, signed and unsigned
    expect_beat(32'h100, 1'b0, 32'h0, 4'b1000, 32'hAB000000);
    expect_resp(32'hFFFFFFAB, 1'b0);
    send_req(1'b0, OP_B, 32'h103, 32'h0);
    serve_beat(0);
    take_resp(0);
    expect_beat(32'h100, 1'b0, 32'h0, 4'b1000, 32'hAB000000);
    expect_resp(32'h000000AB, 1'b0);
    send_req(1'b0, OP_BU, 32'h103, 32'h0);
    serve_beat(0);
    take_resp(0);

    // Crossing halfword load, positive then negative
    expect_beat(32'h0FC, 1'b0, 32'h0, 4'b1000, 32'h11000000);
    expect_beat(32'h100, 1'b0, 32'h0, 4'b0001, 32'h00000022);
    expect_resp(32'h00002211, 1'b0);
    send_req(1'b0, OP_H, 32'h0FF, 32'h0);
    serve_beat(0);
    serve_beat(0);
    take_resp(0);
    expect_beat(32'h0FC, 1'b0, 32'h0, 4'b1000, 32'h88000000);
    expect_beat(32'h100, 1'b0, 32'h0, 4'b0001, 32'h000000FF);
    expect_resp(32'hFFFFFF88, 1'b0);
    send_req(1'b0, OP_H, 32'h0FF, 32'h0);
    serve_beat(0);
    serve_beat(0);
    take_resp(0);

    // Crossing halfword store with memory and response stalls
    expect_beat(32'h0FC, 1'b1, 32'h44000000, 4'b1000, 32'h0);
    expect_beat(32'h100, 1'b1, 32'h00000033, 4'b0001, 32'h0);
    expect_resp(32'h0, 1'b0);
    send_req(1'b1, OP_H, 32'h0FF, 32'h00003344);
    serve_beat(3);
    serve_beat(0);
    take_resp(2);

    // Crossing word load at the top of the address space wraps to 0
    expect_beat(32'hFFFFFFFC, 1'b0, 32'h0, 4'b1100, 32'h22110000);
    expect_beat(32'h00000000, 1'b0, 32'h0, 4'b0011, 32'h00004433);
    expect_resp(32'h44332211, 1'b0);
    send_req(1'b0, OP_W, 32'hFFFFFFFE, 32'h0);
    serve_beat(0);
    serve_beat(0);
    take_resp(0);

    // Ops illegal at XLEN=32: error response, no memory beat
    expect_resp(32'h0, 1'b1);
    send_req(1'b0, OP_D, 32'h100, 32'h0);
    chk("illegal_d_mem_valid", 32'(mem_req_valid), 32'd0);
    take_resp(0);
    expect_resp(32'h0, 1'b1);
    send_req(1'b0, OP_WU, 32'h100, 32'h0);
    chk("illegal_wu_mem_valid", 32'(mem_req_valid), 32'd0);
    take_resp(1);

    // Misaligned word load on the non-splitting instance
    n = 0;
    while (n_req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("na_req_ready", 32'(n_req_ready), 32'd1);
    n_req_valid = 1'b1; n_req_wen = 1'b0; n_req_op = OP_W; n_req_addr = 32'h102;
    @(posedge clk); #1;
    n_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("na_resp_valid", 32'(n_resp_valid), 32'd1);
      chk("na_resp_err",   32'(n_resp_err), 32'd1);
      chk("na_resp_rdata", n_resp_rdata, 32'd0);
      chk("na_mem_valid",  32'(n_mem_req_valid), 32'd0);
      @(posedge clk); #1;
    end
    n_resp_ready = 1'b1;
    @(posedge clk); #1;
    n_resp_ready = 1'b0;
    chk("na_resp_drop", 32'(n_resp_valid), 32'd0);

    // Reset while waiting for the memory response
    send_req(1'b0, OP_W, 32'h140, 32'h0);
    chk("rst_mid_mem_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_rst_mem_valid",  32'(mem_req_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Normal transaction after the aborted one
    expect_beat(32'h200, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D);
    expect_resp(32'hCAFEF00D, 1'b0);
    send_req(1'b0, OP_W, 32'h200, 32'h0);
    serve_beat(0);
    take_resp(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
